// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared definitions for the data-memory controller: sequencer
//                state encoding, CPU access-width mask constants and the
//                mask-to-byte-count helper.
//                The VID_ACC state exists only when DMEM_CTRL_VID_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CPU_ACC = 3'd1,
`ifdef DMEM_CTRL_VID_EN
        ST_VID_ACC = 3'd2,
`endif
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } dmem_state_t;

    localparam logic [7:0] c_WIDTH_B = 8'h01;
    localparam logic [7:0] c_WIDTH_H = 8'h03;
    localparam logic [7:0] c_WIDTH_W = 8'h0F;
    localparam logic [7:0] c_WIDTH_D = 8'hFF;

    // Byte count for a legal width mask; 0 flags an illegal mask.
    function automatic logic [3:0] width_to_n(input logic [7:0] mask);
        case (mask)
            c_WIDTH_B: width_to_n = 4'd1;
            c_WIDTH_H: width_to_n = 4'd2;
            c_WIDTH_W: width_to_n = 4'd4;
            c_WIDTH_D: width_to_n = 4'd8;
            default:   width_to_n = 4'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arb.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb
//  Description : CPU/video arbiter with starvation limit. CPU wins ties until
//                STARVE_LIM consecutive CPU grants have been issued while the
//                video request was pending; then video is granted once.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                i_idle            - sequencer can accept a new grant
//                i_cpu_req/i_vid_req - requests
//                o_gnt_cpu/o_gnt_vid - one-cycle grants (only while i_idle)
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arb #(
    parameter int STARVE_LIM = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_idle,
    input  logic i_cpu_req,
    input  logic i_vid_req,
    output logic o_gnt_cpu,
    output logic o_gnt_vid
);

    localparam int                 c_CNT_W = $clog2(STARVE_LIM + 1);
    localparam logic [c_CNT_W-1:0] c_LIM   = c_CNT_W'(STARVE_LIM);

    logic [c_CNT_W-1:0] r_starve;
    logic               w_starved;

    assign w_starved = (r_starve == c_LIM);
    assign o_gnt_vid = i_idle & i_vid_req & (~i_cpu_req | w_starved);
    assign o_gnt_cpu = i_idle & i_cpu_req & ~o_gnt_vid;

    // Counter saturates at the limit; any video grant or idle video side clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (!i_vid_req || o_gnt_vid) begin
            r_starve <= '0;
        end else if (o_gnt_cpu && !w_starved) begin
            r_starve <= r_starve + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_ctrl
//  Description : Sequencer for a single-port byte-wide data RAM shared by a
//                CPU load/store port and a video window refresh port. Issues
//                one byte per cycle, one DRAIN cycle, then a DONE cycle that
//                pulses the owner's ready and presents its data.
//  Ports       : sys_clk/sys_rst            - clock, sync active-high reset
//                cpu_req/we/addr/width/wdata - CPU request (latched at grant)
//                cpu_ready/cpu_rdata        - CPU completion pulse / load data
//                vid_req/vid_ready/vid_data - video window refresh
//                ram_en/we/addr/wdata/rdata - byte RAM (1-cycle read latency)
//  Config      : define DMEM_CTRL_VID_EN to build the video port and arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = 7,
    parameter int VMEM_BASE  = 120,
    parameter int STARVE_LIM = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_width,
    input  logic [63:0]       cpu_wdata,
    output logic              cpu_ready,
    output logic [63:0]       cpu_rdata,
    input  logic              vid_req,
    output logic              vid_ready,
    output logic [63:0]       vid_data,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    dmem_state_t       r_state, w_state_nxt;
    logic [2:0]        r_idx, r_last, r_cap_idx;
    logic              r_we, r_cap_vld;
    logic [ADDR_W-1:0] r_addr;
    logic [63:0]       r_wdata, r_buf, w_buf_nxt, r_cpu_rdata;
    logic              w_idle, w_gnt_cpu, w_acc, w_ram_we;
    logic [3:0]        w_cpu_n;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_cpu_n = width_to_n(cpu_width);

`ifdef DMEM_CTRL_VID_EN
    logic        w_gnt_vid, r_vid_own;
    logic [63:0] r_vid_data;

    dmem_arb #(
        .STARVE_LIM (STARVE_LIM)
    ) u_arb (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .i_idle    (w_idle),
        .i_cpu_req (cpu_req),
        .i_vid_req (vid_req),
        .o_gnt_cpu (w_gnt_cpu),
        .o_gnt_vid (w_gnt_vid)
    );

    assign w_acc     = (r_state == ST_CPU_ACC) || (r_state == ST_VID_ACC);
    assign cpu_ready = (r_state == ST_DONE) & ~r_vid_own;
    assign vid_ready = (r_state == ST_DONE) & r_vid_own;
    assign vid_data  = r_vid_data;
`else
    localparam int c_unused_vmem = VMEM_BASE;
    localparam int c_unused_lim  = STARVE_LIM;
    logic w_unused_vid;

    assign w_unused_vid = vid_req;
    assign w_gnt_cpu    = w_idle & cpu_req;
    assign w_acc        = (r_state == ST_CPU_ACC);
    assign cpu_ready    = (r_state == ST_DONE);
    assign vid_ready    = 1'b0;
    assign vid_data     = '0;
`endif

    assign cpu_rdata = r_cpu_rdata;

    // RAM port is decoded from the access state so it is quiet in every other state.
    assign w_ram_we  = (r_state == ST_CPU_ACC) & r_we;
    assign ram_en    = w_acc;
    assign ram_we    = w_ram_we;
    assign ram_addr  = w_acc ? (r_addr + ADDR_W'(r_idx)) : '0;
    assign ram_wdata = w_ram_we ? r_wdata[{r_idx, 3'b000} +: 8] : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
`ifdef DMEM_CTRL_VID_EN
                if (w_gnt_vid) begin
                    w_state_nxt = ST_VID_ACC;
                end else
`endif
                if (w_gnt_cpu) begin
                    w_state_nxt = (w_cpu_n == 4'd0) ? ST_DONE : ST_CPU_ACC;
                end
            end
            ST_CPU_ACC: if (r_idx == r_last) w_state_nxt = ST_DRAIN;
`ifdef DMEM_CTRL_VID_EN
            ST_VID_ACC: if (r_idx == r_last) w_state_nxt = ST_DRAIN;
`endif
            ST_DRAIN:   w_state_nxt = ST_DONE;
            ST_DONE:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Read byte issued last cycle lands in the assembly buffer this cycle.
    always_comb begin
        w_buf_nxt = r_buf;
        if (r_cap_vld) begin
            w_buf_nxt[{r_cap_idx, 3'b000} +: 8] = ram_rdata;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_last      <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_buf       <= '0;
            r_cap_vld   <= 1'b0;
            r_cap_idx   <= '0;
            r_cpu_rdata <= '0;
`ifdef DMEM_CTRL_VID_EN
            r_vid_own   <= 1'b0;
            r_vid_data  <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cap_vld <= w_acc & ~w_ram_we;
            r_cap_idx <= r_idx;
            r_buf     <= w_buf_nxt;
            if (w_acc) begin
                r_idx <= r_idx + 3'd1;
            end
            if (w_gnt_cpu) begin
                r_we    <= cpu_we;
                r_addr  <= cpu_addr;
                r_wdata <= cpu_wdata;
                r_idx   <= '0;
                r_last  <= 3'(w_cpu_n - 4'd1);
                r_buf   <= '0;
                if (w_cpu_n == 4'd0) begin
                    r_cpu_rdata <= '0;
                end
`ifdef DMEM_CTRL_VID_EN
                r_vid_own <= 1'b0;
`endif
            end
`ifdef DMEM_CTRL_VID_EN
            if (w_gnt_vid) begin
                r_vid_own <= 1'b1;
                r_we      <= 1'b0;
                r_addr    <= ADDR_W'(VMEM_BASE);
                r_idx     <= '0;
                r_last    <= 3'd7;
                r_buf     <= '0;
            end
            if (r_state == ST_DRAIN) begin
                if (r_vid_own) begin
                    r_vid_data <= w_buf_nxt;
                end else if (!r_we) begin
                    r_cpu_rdata <= w_buf_nxt;
                end
            end
`else
            if ((r_state == ST_DRAIN) && !r_we) begin
                r_cpu_rdata <= w_buf_nxt;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_ctrl
//  Description : Scoreboard bench for dmem_ctrl with a behavioural byte RAM.
//                Stimulus pushes expected completions (port, cycle, data);
//                a monitor pops and compares on every ready pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        cpu_req, cpu_we;
    logic [6:0]  cpu_addr;
    logic [7:0]  cpu_width;
    logic [63:0] cpu_wdata;
    logic        cpu_ready;
    logic [63:0] cpu_rdata;
    logic        vid_req, vid_ready;
    logic [63:0] vid_data;
    logic        ram_en, ram_we;
    logic [6:0]  ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;

    typedef struct {
        bit          vid;
        int          cyc;
        logic [63:0] data;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  mem [0:127];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    int          n_en = 0;
    int          n_vid_rdy = 0;

    dmem_ctrl #(
        .ADDR_W     (7),
        .VMEM_BASE  (120),
        .STARVE_LIM (4)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_width (cpu_width),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .vid_req   (vid_req),
        .vid_ready (vid_ready),
        .vid_data  (vid_data),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Byte RAM: read data valid the cycle after the enable.
    always @(posedge sys_clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] = ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every ready pulse against the scoreboard head.
    always @(negedge sys_clk) begin
        exp_t e;
        if (ram_en === 1'b1) n_en++;
        if (vid_ready === 1'b1) n_vid_rdy++;
        if (ram_we === 1'b1 && ram_en !== 1'b1) check("ram_we_without_en", 64'd1, 64'd0);
        if (cpu_ready === 1'b1 || vid_ready === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_ready", {62'd0, vid_ready, cpu_ready}, 64'd0);
            end else begin
                e = q.pop_front();
                check("ready_port", {63'd0, vid_ready}, {63'd0, e.vid});
                check("ready_cycle", 64'(cyc), 64'(e.cyc));
                if (e.vid) check("vid_data", vid_data, e.data);
                else       check("cpu_rdata", cpu_rdata, e.data);
            end
        end
    end

    task automatic wait_done();
        for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge sys_clk);
        if (q.size() != 0) begin
            check("timeout_pending", 64'(q.size()), 64'd0);
            q.delete();
        end
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic cpu_op(input logic we, input logic [6:0] addr, input logic [7:0] width,
                          input logic [63:0] wdata, input int lat, input logic [63:0] exp);
        @(negedge sys_clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_width = width;
        cpu_wdata = wdata;
        q.push_back('{vid: 1'b0, cyc: cyc + lat, data: exp});
        @(negedge sys_clk);
        // Scramble inputs after the grant; the latched operation must be unaffected.
        cpu_req   = 1'b0;
        cpu_we    = ~we;
        cpu_addr  = ~addr;
        cpu_width = 8'hFF;
        cpu_wdata = ~wdata;
        wait_done();
    endtask

    initial begin
        int a;
        int e0;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++)   mem[8'h10 + i] = 8'(i + 1);
        for (int i = 0; i < 8; i++)   mem[120 + i]   = 8'(8'hA0 + i);
        mem[1] = 8'h11;

        sys_rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
        cpu_width = 8'h01; cpu_wdata = '0; vid_req = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_cpu_ready", {63'd0, cpu_ready}, 64'd0);
        check("rst_vid_ready", {63'd0, vid_ready}, 64'd0);
        check("rst_ram_en",    {63'd0, ram_en},    64'd0);
        check("rst_ram_we",    {63'd0, ram_we},    64'd0);
        check("rst_ram_addr",  64'(ram_addr),      64'd0);
        check("rst_ram_wdata", 64'(ram_wdata),     64'd0);
        check("rst_cpu_rdata", cpu_rdata,          64'd0);
        check("rst_vid_data",  vid_data,           64'd0);
        sys_rst = 1'b0;

        cpu_op(1'b0, 7'h10, 8'hFF, 64'h0, 10, 64'h0807060504030201);
        cpu_op(1'b1, 7'h7F, 8'h03, 64'hAABB, 4, 64'h0807060504030201);
        check("store_byte0_at_7f", 64'(mem[8'h7F]), 64'hBB);
        check("store_byte1_wrap",  64'(mem[0]),     64'hAA);
        cpu_op(1'b0, 7'h7F, 8'h03, 64'h0, 4, 64'hAABB);
        cpu_op(1'b0, 7'h12, 8'h01, 64'h0, 3, 64'h03);
        cpu_op(1'b0, 7'h7E, 8'h0F, 64'h0, 6, 64'h11AABBA6);

        e0 = n_en;
        cpu_op(1'b0, 7'h10, 8'h07, 64'h0, 1, 64'h0);
        check("illegal_no_ram_cycles", 64'(n_en - e0), 64'd0);

`ifdef DMEM_CTRL_VID_EN
        // Both requests held: four CPU grants, then one video grant.
        @(negedge sys_clk);
        a = cyc;
        cpu_req = 1'b1; vid_req = 1'b1; cpu_we = 1'b0;
        cpu_addr = 7'h10; cpu_width = 8'hFF; cpu_wdata = '0;
        for (int k = 0; k < 4; k++)
            q.push_back('{vid: 1'b0, cyc: a + 10 + 11 * k, data: 64'h0807060504030201});
        q.push_back('{vid: 1'b1, cyc: a + 54, data: 64'hBBA6A5A4A3A2A1A0});
        q.push_back('{vid: 1'b0, cyc: a + 65, data: 64'h0807060504030201});
        for (int i = 0; i < 200 && cyc < a + 56; i++) @(negedge sys_clk);
        cpu_req = 1'b0; vid_req = 1'b0;
        wait_done();
`else
        // Video port absent: vid_req must have no effect.
        vid_req = 1'b1;
        cpu_op(1'b0, 7'h10, 8'h0F, 64'h0, 6, 64'h04030201);
        repeat (5) @(negedge sys_clk);
        vid_req = 1'b0;
        check("no_vid_ready", 64'(n_vid_rdy), 64'd0);
        check("vid_data_zero", vid_data, 64'd0);
`endif

        // Reset during an 8-byte load: aborted, nothing reported.
        @(negedge sys_clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h10; cpu_width = 8'hFF;
        @(negedge sys_clk);
        cpu_req = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check("abort_ram_en",    {63'd0, ram_en},    64'd0);
        check("abort_ram_we",    {63'd0, ram_we},    64'd0);
        check("abort_cpu_ready", {63'd0, cpu_ready}, 64'd0);
        check("abort_cpu_rdata", cpu_rdata,          64'd0);
        check("abort_ram_addr",  64'(ram_addr),      64'd0);
        e0 = n_en;
        repeat (15) @(negedge sys_clk);
        check("abort_no_more_ram", 64'(n_en - e0), 64'd0);

        cpu_op(1'b0, 7'h10, 8'h01, 64'h0, 3, 64'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, byte-address width of data RAM (128 bytes).
REQ-002 SHALL have parameter VMEM_BASE, default 120, first byte of the 8-byte video window.
REQ-003 SHALL have parameter STARVE_LIM, default 4, max consecutive CPU grants while vid_req pending.
REQ-004 SHALL have ports, in order:
- sys_clk  in  1  sole clock, rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU load/store request.
- cpu_we  in  1  1=store, 0=load.
- cpu_addr  in  ADDR_W  start byte address.
- cpu_width  in  8  byte mask: 8'h01, 8'h03, 8'h0F, 8'hFF.
- cpu_wdata  in  64  store data, byte 0 at [7:0].
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  64  load data, zero-extended.
- vid_req  in  1  video window refresh request.
- vid_ready  out  1  one-cycle completion pulse.
- vid_data  out  64  window bytes, VMEM_BASE+0 at [7:0].
- ram_en, ram_we  out  1 each  byte RAM enable / write.
- ram_addr  out  ADDR_W  byte address.
- ram_wdata  out  8  write byte.
- ram_rdata  in  8  read byte, valid the cycle after ram_en with ram_we=0.

Function
REQ-005 SHALL sequence a single-port byte RAM, one byte per cycle, shared by CPU and video ports.
REQ-006 SHALL implement states IDLE, CPU_ACC, VID_ACC, DRAIN, DONE.
REQ-007 In IDLE with one request, SHALL grant it; with both, SHALL grant CPU unless starve counter == STARVE_LIM, then video.
REQ-008 Starve counter SHALL increment on each CPU grant while vid_req=1, clear on video grant or vid_req=0, saturate at STARVE_LIM.
REQ-009 At grant cycle A, SHALL latch cpu_we/addr/width/wdata; later input changes or dropped req SHALL not affect the operation.
REQ-010 N = 1/2/4/8 for widths 01/03/0F/FF; byte i SHALL be driven on ram_addr in cycle A+1+i, address modulo 2^ADDR_W.
REQ-011 Stores: ram_en=ram_we=1, ram_wdata=wdata byte i in those cycles.
REQ-012 Loads: SHALL capture ram_rdata into byte i in cycle A+2+i; bytes >= N SHALL be 0.
REQ-013 After last issue, SHALL spend one DRAIN cycle (both loads and stores), then DONE; ready pulses in cycle A+N+2.
REQ-014 cpu_rdata/vid_data SHALL update only at their DONE and hold otherwise; stores SHALL leave cpu_rdata unchanged.
REQ-015 Illegal cpu_width SHALL issue no RAM cycle, go straight to DONE (cpu_ready at A+1), cpu_rdata=0.
REQ-016 Video access SHALL read 8 bytes from VMEM_BASE (wrapping), same timing as 8-byte load, pulse vid_ready at A+10.
REQ-017 DONE SHALL return to IDLE; earliest next grant is the cycle after DONE.
REQ-018 ram_en SHALL be 0 in IDLE, DRAIN, DONE; ram_we SHALL be 0 whenever ram_en=0.

Reset
REQ-019 sys_rst=1 SHALL force IDLE, starve counter 0, cpu_ready=vid_ready=ram_en=ram_we=0, cpu_rdata=vid_data=0, ram_addr=ram_wdata=0.
REQ-020 Reset mid-operation SHALL abort it; no ready pulse, no further RAM cycles for it.

Configuration
REQ-021 With DMEM_CTRL_VID_EN defined, video port and arbitration SHALL operate as above.
REQ-022 Without it, vid_req SHALL be ignored, vid_ready=0, vid_data=0, VID_ACC and starve counter absent; CPU timing unchanged.

Structure
REQ-023 State encoding, width-mask constants, and mask-to-N function SHALL reside in shared package dmem_pkg.
REQ-024 Arbitration and starve counter SHALL be sub-module dmem_arb; sequencer stays in dmem_ctrl.

Verification
REQ-025 Load 8'hFF from 0x10, RAM 0x10..0x17 = 01..08 -> cpu_ready at A+10, cpu_rdata=64'h0807060504030201.
REQ-026 Store 8'h03 of 64'hAABB to 0x7F -> writes BB at 0x7F, AA at 0x00; cpu_ready at A+4.
REQ-027 cpu_req and vid_req held high continuously -> 4 CPU grants then 1 video grant, repeating; vid_data = bytes 120..127.
REQ-028 cpu_width=8'h07 -> no ram_en, cpu_ready at A+1, cpu_rdata=0.
REQ-029 sys_rst pulsed at A+3 of 8-byte load -> no cpu_ready, ram_en=0 next cycle, all outputs 0.
REQ-030 Build without DMEM_CTRL_VID_EN, vid_req=1 -> vid_ready never 1, CPU load 8'h0F completes at A+6.
